// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types for the instruction/data memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Width needed to hold values 0..limit inclusive.
  function automatic int unsigned ctr_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : arb_starve_ctr
// Brief    : Counts consecutive data-port grants taken while a fetch waits;
//            o_limit_hit lets the fetch port win the next arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_ctr
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_arb_fire,
  input  logic i_fetch_wait,
  input  logic i_grant_fetch,
  output logic o_limit_hit
);

  localparam int unsigned c_cnt_w = ctr_width(STARVE_LIMIT);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_arb_fire) begin
      // Only a data grant that overtook a waiting fetch counts as starvation.
      if (i_grant_fetch || !i_fetch_wait) begin
        r_cnt <= '0;
      end else if (r_cnt != c_limit) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_limit_hit = (r_cnt == c_limit);

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between fetch (I) and load/store (D),
//            one transaction outstanding. Optional fetch starvation guard
//            enabled by defining ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic              m_req_we,
  output logic [DATA_W-1:0] m_req_wdata,
  input  logic              m_rsp_valid,
  input  logic [DATA_W-1:0] m_rsp_rdata
);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  arb_owner_e        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;

  logic w_arb_fire;
  logic w_grant_fetch;
  logic w_grant_data;

  assign w_arb_fire = (r_state == IDLE) && (i_req_valid || d_req_valid);

`ifdef ARB_STARVE_GUARD_EN
  logic w_limit_hit;

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk           (clk),
    .reset         (reset),
    .i_arb_fire    (w_arb_fire),
    .i_fetch_wait  (i_req_valid),
    .i_grant_fetch (w_grant_fetch),
    .o_limit_hit   (w_limit_hit)
  );

  assign w_grant_fetch = i_req_valid && (!d_req_valid || w_limit_hit);
`else
  logic w_unused_limit;

  assign w_unused_limit = |STARVE_LIMIT;
  assign w_grant_fetch  = i_req_valid && !d_req_valid;
`endif

  assign w_grant_data = d_req_valid && !w_grant_fetch;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latch: captured at the arbitration cycle, replayed in REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_I;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_arb_fire) begin
      if (w_grant_fetch) begin
        r_owner <= OWN_I;
        r_addr  <= i_req_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
      end else begin
        r_owner <= OWN_D;
        r_addr  <= d_req_addr;
        r_we    <= d_req_we;
        r_wdata <= d_req_wdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_req_valid || d_req_valid) w_next_state = REQ;
      REQ:     if (m_req_ready)                w_next_state = RSP;
      RSP:     if (m_rsp_valid)                w_next_state = IDLE;
      default:                                 w_next_state = IDLE;
    endcase
  end

  // Output logic; ready is qualified by reset so it drops the moment reset asserts.
  always_comb begin
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    m_req_valid = 1'b0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        i_req_ready = reset && w_grant_fetch;
        d_req_ready = reset && w_grant_data;
      end
      REQ: begin
        m_req_valid = reset;
      end
      RSP: begin
        i_rsp_valid = reset && m_rsp_valid && (r_owner == OWN_I);
        d_rsp_valid = reset && m_rsp_valid && (r_owner == OWN_D);
      end
      default: begin
        m_req_valid = 1'b0;
      end
    endcase
  end

  assign m_req_addr  = r_addr;
  assign m_req_we    = r_we;
  assign m_req_wdata = r_wdata;
  assign i_rsp_rdata = m_rsp_rdata;
  assign d_rsp_rdata = m_rsp_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [63:0] i_req_addr, i_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [63:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic        m_req_valid, m_req_ready, m_req_we, m_rsp_valid;
  logic [63:0] m_req_addr, m_req_wdata, m_rsp_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_wdata(m_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return (a == 64'h100) ? 64'h13 : (a ^ 64'hA5A5_0000_0000_5A5A);
  endfunction

  // Transaction-level model: at most one pending request, issued or not.
  bit          md_busy, md_issued;
  arb_owner_e  md_owner;
  logic [63:0] md_addr, md_wdata;
  logic        md_we;
  int          md_starve;

  // Observations sampled at negedge.
  logic        mon_acc = 1'b0, mon_mvalid = 1'b0, mon_i_ready = 1'b0, mon_d_ready = 1'b0;
  logic [63:0] mon_addr;
  int          cyc = 0, i_rsp_cnt = 0, d_rsp_cnt = 0, stall_seen = 0;
  logic [63:0] last_i_rdata, last_d_rdata;
  int          last_i_gnt_cyc, last_i_rsp_cyc;
  arb_owner_e  gnt_log[$];
  bit          cap_done;
  logic [63:0] cap_addr, cap_wdata;
  logic        cap_we;

  always @(negedge clk) begin
    logic exp_ir, exp_dr, exp_mv, exp_iv, exp_dv;
    bit   gi;
    cyc++;
    mon_acc     = m_req_valid && m_req_ready;
    mon_mvalid  = m_req_valid;
    mon_addr    = m_req_addr;
    mon_i_ready = i_req_ready;
    mon_d_ready = d_req_ready;
    if (i_rsp_valid) begin i_rsp_cnt++; last_i_rdata = i_rsp_rdata; last_i_rsp_cyc = cyc; end
    if (d_rsp_valid) begin d_rsp_cnt++; last_d_rdata = d_rsp_rdata; end
    if (i_req_ready) begin gnt_log.push_back(OWN_I); last_i_gnt_cyc = cyc; end
    if (d_req_ready) gnt_log.push_back(OWN_D);
    if (m_req_valid && !cap_done) begin
      cap_done = 1'b1; cap_addr = m_req_addr; cap_we = m_req_we; cap_wdata = m_req_wdata;
    end
    if (m_req_valid && !m_req_ready && !i_req_ready && !d_req_ready) stall_seen++;

    if (!reset) begin
      chk("reset_outputs", {i_req_ready, d_req_ready, m_req_valid, i_rsp_valid, d_rsp_valid}, 64'd0);
      md_busy = 1'b0; md_issued = 1'b0; md_starve = 0;
    end else begin
      gi = i_req_valid && (!d_req_valid || (GUARD && md_starve >= LIMIT));
      exp_ir = 1'b0; exp_dr = 1'b0; exp_mv = 1'b0; exp_iv = 1'b0; exp_dv = 1'b0;
      if (!md_busy) begin
        exp_ir = gi;
        exp_dr = d_req_valid && !gi;
      end else if (!md_issued) begin
        exp_mv = 1'b1;
      end else begin
        exp_iv = m_rsp_valid && (md_owner == OWN_I);
        exp_dv = m_rsp_valid && (md_owner == OWN_D);
      end
      chk("handshake{ir,dr,mv,iv,dv}", {i_req_ready, d_req_ready, m_req_valid, i_rsp_valid, d_rsp_valid},
          {exp_ir, exp_dr, exp_mv, exp_iv, exp_dv});
      if (exp_mv) begin
        chk("m_req_addr", m_req_addr, md_addr);
        chk("m_req_we", m_req_we, md_we);
        if (md_we) chk("m_req_wdata", m_req_wdata, md_wdata);
      end
      if (exp_iv) chk("i_rsp_rdata", i_rsp_rdata, m_rsp_rdata);
      if (exp_dv) chk("d_rsp_rdata", d_rsp_rdata, m_rsp_rdata);

      if (!md_busy) begin
        if (i_req_valid || d_req_valid) begin
          md_busy   = 1'b1;
          md_issued = 1'b0;
          md_owner  = gi ? OWN_I : OWN_D;
          md_addr   = gi ? i_req_addr : d_req_addr;
          md_we     = gi ? 1'b0 : d_req_we;
          md_wdata  = d_req_wdata;
          if (gi || !i_req_valid) md_starve = 0;
          else if (md_starve < LIMIT) md_starve++;
        end
      end else if (!md_issued) begin
        if (m_req_ready) md_issued = 1'b1;
      end else if (m_rsp_valid) begin
        md_busy = 1'b0;
      end
    end
  end

  // Memory responder: accepts immediately unless stalled, answers the cycle after acceptance.
  bit          mem_auto = 1'b1, rsp_hold = 1'b0, pend = 1'b0;
  logic [63:0] pend_addr;
  int          stall_cnt = 0;

  initial begin
    m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_auto) begin
        m_rsp_valid = 1'b0;
        if (mon_acc) begin pend = 1'b1; pend_addr = mon_addr; end
        if (pend && !rsp_hold) begin
          m_rsp_valid = 1'b1; m_rsp_rdata = mem_word(pend_addr); pend = 1'b0;
        end
        if (stall_cnt > 0 && mon_mvalid) stall_cnt--;
        m_req_ready = (stall_cnt == 0);
      end
    end
  end

  // Raise requests, drop each as soon as its grant is seen. Called at posedge+1.
  task automatic issue(input bit use_i, input logic [63:0] ai, input bit use_d,
                       input logic [63:0] ad, input logic we, input logic [63:0] wd,
                       output int waited);
    i_req_valid = use_i; i_req_addr = ai;
    d_req_valid = use_d; d_req_addr = ad; d_req_we = we; d_req_wdata = wd;
    waited = 0;
    for (int k = 0; k < 100 && (i_req_valid || d_req_valid); k++) begin
      @(posedge clk); #1;
      waited++;
      if (mon_i_ready) i_req_valid = 1'b0;
      if (mon_d_ready) d_req_valid = 1'b0;
    end
    chk("issue_timeout", {i_req_valid, d_req_valid}, 64'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    for (int k = 0; k < 200 && md_busy; k++) begin @(posedge clk); #1; end
    chk("quiet_timeout", md_busy, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    i_rsp_cnt = 0; d_rsp_cnt = 0; stall_seen = 0; cap_done = 1'b0;
    gnt_log.delete();
  endtask

  initial begin
    int         w;
    logic       act_o;
    arb_owner_e exp_o;
    // Requests held high through reset must not see ready.
    reset = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 64'h40;
    d_req_valid = 1'b1; d_req_addr = 64'h80; d_req_we = 1'b0; d_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Fetch only
    clear_obs();
    issue(1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 64'h0, w);
    chk("t1_grant_wait", w, 1);
    wait_quiet();
    chk("t1_i_rsp_cnt", i_rsp_cnt, 1);
    chk("t1_i_rdata", last_i_rdata, 64'h13);
    chk("t1_d_rsp_cnt", d_rsp_cnt, 0);
    chk("t1_latency", last_i_rsp_cyc - last_i_gnt_cyc, 2);

    // Simultaneous fetch and store: data first
    clear_obs();
    issue(1'b1, 64'h200, 1'b1, 64'h1000, 1'b1, 64'hAB, w);
    wait_quiet();
    chk("t2_grants", gnt_log.size(), 2);
    act_o = (gnt_log.size() > 0) ? gnt_log[0] : 1'bx;
    chk("t2_first_owner", act_o, OWN_D);
    act_o = (gnt_log.size() > 1) ? gnt_log[1] : 1'bx;
    chk("t2_second_owner", act_o, OWN_I);
    chk("t2_first_addr", cap_addr, 64'h1000);
    chk("t2_first_we", cap_we, 1'b1);
    chk("t2_first_wdata", cap_wdata, 64'hAB);
    chk("t2_rsp_cnts", {i_rsp_cnt[7:0], d_rsp_cnt[7:0]}, 16'h0101);

    // Both continuously valid
    clear_obs();
    i_req_valid = 1'b1; i_req_addr = 64'h2000;
    d_req_valid = 1'b1; d_req_addr = 64'h3000; d_req_we = 1'b0;
    for (int k = 0; k < 300 && gnt_log.size() < 10; k++) begin @(posedge clk); #1; end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    wait_quiet();
    chk("t3_grant_count", gnt_log.size(), 10);
    for (int k = 0; k < 10; k++) begin
      exp_o = (GUARD && (k % 5 == 4)) ? OWN_I : OWN_D;
      act_o = (k < gnt_log.size()) ? gnt_log[k] : 1'bx;
      chk($sformatf("t3_grant%0d", k), act_o, exp_o);
    end

    // Memory stalls acceptance for 5 cycles
    clear_obs();
    stall_cnt = 5;
    @(posedge clk); #1;
    issue(1'b0, 64'h0, 1'b1, 64'h3000, 1'b0, 64'h0, w);
    wait_quiet();
    chk("t4_stall_cycles", stall_seen, 5);
    chk("t4_d_rsp_cnt", d_rsp_cnt, 1);
    chk("t4_d_rdata", last_d_rdata, mem_word(64'h3000));

    // Reset while waiting for the response, then a stray response
    clear_obs();
    rsp_hold = 1'b1;
    issue(1'b1, 64'h500, 1'b0, 64'h0, 1'b0, 64'h0, w);
    for (int k = 0; k < 50 && !md_issued; k++) begin @(posedge clk); #1; end
    chk("t5_reach_rsp", md_issued, 1'b1);
    mem_auto = 1'b0; pend = 1'b0; m_rsp_valid = 1'b0; m_req_ready = 1'b0;
    reset = 1'b0; d_req_valid = 1'b1; d_req_addr = 64'h700;
    repeat (2) begin @(posedge clk); #1; end
    d_req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    m_rsp_valid = 1'b1; m_rsp_rdata = 64'hDEAD;
    @(posedge clk); #1;
    m_rsp_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_rsp_cnts", {i_rsp_cnt[7:0], d_rsp_cnt[7:0]}, 16'h0000);
    rsp_hold = 1'b0; mem_auto = 1'b1;
    issue(1'b0, 64'h0, 1'b1, 64'h600, 1'b1, 64'h77, w);
    chk("t5_idle_grant_wait", w, 1);
    wait_quiet();
    chk("t5_d_rsp_cnt", d_rsp_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
